pad_group_arbiter: RTL and testbench



---
 rtl/pad_group_arbiter.sv | 151 +++++++++++++++
 tb/tb_pad_group_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_group_arbiter.sv
`default_nettype none
// ============================================================================
// pad_group_arbiter
// Round-robin owner of a shared pad group, with break-before-make dead time
// and optional hold-time preemption.
// Revision: 1.0
// ============================================================================
module pad_group_arbiter #(
  parameter int NumReq     = 4,
  parameter int PinWidth   = 8,
  parameter int TurnCycles = 2,
  parameter int MaxHold    = 0
) (
  input  logic                         clk_sys_i,
  input  logic                         rst_sys_ni,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq*PinWidth-1:0]   req_out_i,
  input  logic [NumReq*PinWidth-1:0]   req_out_en_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [$clog2(NumReq)-1:0]    owner_o,
  output logic [NumReq-1:0]            preempt_o,
  output logic                         busy_o,
  output logic [PinWidth-1:0]          pin_o,
  output logic [PinWidth-1:0]          pin_en_o
);

  localparam int IdxW  = $clog2(NumReq);
  localparam int HoldW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;
  localparam int TurnW = $clog2(TurnCycles + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e              r_state;
  logic [NumReq-1:0]   r_gnt;
  logic [IdxW-1:0]     r_owner;
  logic [IdxW-1:0]     r_last;
  logic [NumReq-1:0]   r_preempt;
  logic [HoldW-1:0]    r_hold;
  logic [TurnW-1:0]    r_turn;

  logic [IdxW-1:0]     w_win;
  logic                w_any;
  logic [NumReq-1:0]   w_win_oh;
  logic                w_owner_req;
  logic                w_others;
  logic                w_timeout;
  logic [PinWidth-1:0] w_pin;
  logic [PinWidth-1:0] w_pin_en;

  // Rotating search starting just after the last winner.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = 1; i <= NumReq; i++) begin
      if (!w_any && req_i[(int'(r_last) + i) % NumReq]) begin
        w_any = 1'b1;
        w_win = IdxW'((int'(r_last) + i) % NumReq);
      end
    end
  end

  assign w_win_oh    = {{(NumReq-1){1'b0}}, 1'b1} << w_win;
  assign w_owner_req = |(req_i & r_gnt);
  assign w_others    = |(req_i & ~r_gnt);
  // Saturated counter keeps the timeout armed until a competitor shows up.
  assign w_timeout   = (MaxHold != 0) && (int'(r_hold) >= MaxHold - 1);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_last    <= IdxW'(NumReq - 1);
      r_preempt <= '0;
      r_hold    <= '0;
      r_turn    <= '0;
    end else begin
      r_preempt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_gnt   <= w_win_oh;
            r_owner <= w_win;
            r_last  <= w_win;
            r_hold  <= '0;
          end
        end
        ST_GRANT: begin
          if (!w_owner_req) begin
            r_state <= ST_TURN;
            r_gnt   <= '0;
            r_turn  <= TurnW'(TurnCycles);
          end else if (w_timeout && w_others) begin
            r_state   <= ST_TURN;
            r_gnt     <= '0;
            r_turn    <= TurnW'(TurnCycles);
            r_preempt <= r_gnt;
          end else if (int'(r_hold) < MaxHold) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ST_TURN: begin
          if (r_turn <= TurnW'(1)) begin
            r_turn <= '0;
            if (w_any) begin
              r_state <= ST_GRANT;
              r_gnt   <= w_win_oh;
              r_owner <= w_win;
              r_last  <= w_win;
              r_hold  <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_turn <= r_turn - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Grant is one-hot or zero, so OR-ing masked slices selects only the owner.
  always_comb begin
    w_pin    = '0;
    w_pin_en = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (r_gnt[k]) begin
        w_pin    = w_pin    | req_out_i[k*PinWidth +: PinWidth];
        w_pin_en = w_pin_en | req_out_en_i[k*PinWidth +: PinWidth];
      end
    end
  end

  assign gnt_o     = r_gnt;
  assign owner_o   = r_owner;
  assign preempt_o = r_preempt;
  assign busy_o    = (r_state != ST_IDLE);
  assign pin_o     = w_pin;
  assign pin_en_o  = w_pin_en;

endmodule
`default_nettype wire

// File: tb/tb_pad_group_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pad_group_arbiter
// Directed and random checks of pad_group_arbiter against an ownership model.
// Revision: 1.0
// ============================================================================
module tb_pad_group_arbiter;

  localparam int NR = 4;
  localparam int PW = 8;
  localparam int TC = 2;
  localparam int MH = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*PW-1:0] dout;
  logic [NR*PW-1:0] den;
  logic [NR-1:0]   gnt;
  logic [1:0]      owner;
  logic [NR-1:0]   pre;
  logic            busy;
  logic [PW-1:0]   pin;
  logic [PW-1:0]   pin_en;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: who owns the pads (-1 = nobody), dead cycles still to run,
  // cycles the owner has held, last winner, and the expected preempt pulse.
  int            m_owner;
  int            m_dead;
  int            m_held;
  int            m_last;
  logic [NR-1:0] m_pre;

  pad_group_arbiter #(
    .NumReq    (NR),
    .PinWidth  (PW),
    .TurnCycles(TC),
    .MaxHold   (MH)
  ) dut (
    .clk_sys_i   (clk),
    .rst_sys_ni  (rst_n),
    .req_i       (req),
    .req_out_i   (dout),
    .req_out_en_i(den),
    .gnt_o       (gnt),
    .owner_o     (owner),
    .preempt_o   (pre),
    .busy_o      (busy),
    .pin_o       (pin),
    .pin_en_o    (pin_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_dead  = 0;
    m_held  = 0;
    m_last  = NR - 1;
    m_pre   = '0;
  endtask

  task automatic model_edge();
    logic [NR-1:0] others;
    int idx;
    m_pre = '0;
    if (m_owner >= 0) begin
      m_held++;
      others = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        m_owner = -1;
        m_dead  = TC;
      end else if (MH > 0 && m_held >= MH && others != '0) begin
        m_pre[m_owner] = 1'b1;
        m_owner = -1;
        m_dead  = TC;
      end
    end else begin
      if (m_dead > 0) m_dead--;
      if (m_dead == 0) begin
        for (int i = 1; i <= NR; i++) begin
          idx = (m_last + i) % NR;
          if (m_owner < 0 && req[idx]) begin
            m_owner = idx;
            m_last  = idx;
            m_held  = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [NR-1:0] eg;
    logic [PW-1:0] ep;
    logic [PW-1:0] epe;
    eg  = '0;
    ep  = '0;
    epe = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ep  = dout[m_owner*PW +: PW];
      epe = den[m_owner*PW +: PW];
      chk("owner", 32'(owner), 32'(m_owner));
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_owner >= 0 || m_dead > 0));
    chk("preempt", 32'(pre), 32'(m_pre));
    chk("pin", 32'(pin), 32'(ep));
    chk("pin_en", 32'(pin_en), 32'(epe));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    // Reset held low with random inputs
    rst_n = 1'b0;
    req   = 4'($urandom);
    dout  = $urandom;
    den   = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_pin_en", 32'(pin_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_preempt", 32'(pre), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    model_reset();
    req   = '0;
    rst_n = 1'b1;
    repeat (2) step();

    // Contention and dead time
    req = 4'b1001;
    step();
    chk("cont_first", 32'(gnt), 32'h1);
    repeat (3) step();
    req = 4'b1000;
    step();
    chk("dead1_gnt", 32'(gnt), 32'h0);
    chk("dead1_en", 32'(pin_en), 32'h0);
    step();
    chk("dead2_gnt", 32'(gnt), 32'h0);
    chk("dead2_en", 32'(pin_en), 32'h0);
    step();
    chk("cont_next", 32'(gnt), 32'h8);
    req = '0;
    repeat (4) step();

    // Single request with known slice data
    dout[2*PW +: PW] = 8'hA5;
    den[2*PW +: PW]  = 8'hFF;
    req = 4'b0100;
    step();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_owner", 32'(owner), 32'd2);
    chk("single_pin", 32'(pin), 32'hA5);
    chk("single_en", 32'(pin_en), 32'hFF);
    step();

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("areset_gnt", 32'(gnt), 32'h0);
    chk("areset_en", 32'(pin_en), 32'h0);
    chk("areset_busy", 32'(busy), 32'h0);
    model_reset();
    req = 4'b1111;
    #2 rst_n = 1'b1;

    // Round-robin rotation with everyone requesting
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 10 && gnt == '0; k++) step();
      chk("rot_granted", 32'(gnt != '0), 32'd1);
      chk("rot_order", 32'(owner), 32'(g % NR));
      if (g < 4) begin
        req[owner] = 1'b0;
        step();
        req = 4'b1111;
      end
    end

    // Preemption: requester 0 owns, requester 1 waits
    req = 4'b0011;
    c = 1;
    for (int k = 0; k < 40 && gnt == 4'b0001; k++) begin
      step();
      if (gnt == 4'b0001) c++;
    end
    chk("hold_cycles", 32'(c), 32'd16);
    chk("preempt_pulse", 32'(pre), 32'h1);
    chk("preempt_gnt", 32'(gnt), 32'h0);
    step();
    chk("preempt_clear", 32'(pre), 32'h0);
    chk("preempt_dead", 32'(gnt), 32'h0);
    step();
    chk("preempt_next", 32'(gnt), 32'h2);

    // Saturated timeout fires as soon as a competitor appears
    req = 4'b0010;
    repeat (20) step();
    chk("sat_keep", 32'(gnt), 32'h2);
    req = 4'b0110;
    step();
    chk("sat_preempt", 32'(pre), 32'h2);
    chk("sat_gnt", 32'(gnt), 32'h0);
    req = '0;
    repeat (4) step();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      end
      dout = $urandom;
      den  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
